// File: rtl/fmac_chan_sched_if.sv
// Channel-request, result and engine-handshake bundle for the shared MAC scheduler.
// master = scheduler side, slave = channels plus engine.
interface fmac_chan_sched_if #(
  parameter int NCH = 4,
  parameter int CHW = 2
);
  logic           enable;
  logic [NCH-1:0] req;
  logic [NCH-1:0] ack;
  logic [CHW-1:0] chan_sel;
  logic           eng_start;
  logic           eng_done;
  logic [14:0]    eng_se;
  logic [14:0]    eng_sez;
  logic           res_valid;
  logic [CHW-1:0] res_chan;
  logic [14:0]    res_se;
  logic [14:0]    res_sez;
  logic           res_err;
  logic           busy;

  modport master (
    input  enable, req, eng_done, eng_se, eng_sez,
    output ack, chan_sel, eng_start, res_valid, res_chan, res_se, res_sez, res_err, busy
  );

  modport slave (
    output enable, req, eng_done, eng_se, eng_sez,
    input  ack, chan_sel, eng_start, res_valid, res_chan, res_se, res_sez, res_err, busy
  );
endinterface

// File: rtl/fmac_chan_sched.sv
// Round-robin scheduler sharing one bit-serial MAC engine among NCH ADPCM channels,
// with start/done handshake tracking and a watchdog on the engine wait.
//
// state     | meaning
// IDLE      | waiting for enable, a request and an idle engine; picks the next channel
// LAUNCH    | chan_sel settled; issue the start pulse and clear the watchdog
// WAIT_LOW  | waiting for the engine to drop done
// WAIT_HIGH | waiting for the engine to raise done again
// CAPTURE   | result strobe and ack visible; record the served channel
module fmac_chan_sched #(
  parameter int NCH     = 4,
  parameter int CHW     = 2,
  parameter int TIMEOUT = 200,
  parameter int TW      = 8
) (
  input logic clk,
  input logic reset,
  fmac_chan_sched_if.master bus
);
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_LOW, WAIT_HIGH, CAPTURE} state_t;

  localparam logic [TW-1:0]  TMAX  = TW'(TIMEOUT - 1);
  localparam logic [CHW:0]   NCH_W = (CHW+1)'(NCH);
  localparam logic [NCH-1:0] ONE   = NCH'(1);

  state_t         state;
  logic [TW-1:0]  timer;
  logic [CHW-1:0] last_grant;

  logic [2*NCH-1:0] req2;
  logic [NCH-1:0]   rot;
  logic             grant_hit;
  logic [CHW:0]     grant_off;
  logic [CHW:0]     grant_sum;
  logic [CHW-1:0]   grant_idx;

  // rot[j] is the request of channel (last_grant+1+j) mod NCH, so the lowest set bit wins
  always_comb begin
    req2      = {bus.req, bus.req};
    rot       = NCH'(req2 >> ({1'b0, last_grant} + 1'b1));
    grant_hit = 1'b0;
    grant_off = '0;
    for (int j = NCH - 1; j >= 0; j--) begin
      if (rot[j[CHW-1:0]]) begin
        grant_hit = 1'b1;
        grant_off = (CHW+1)'(j);
      end
    end
    grant_sum = {1'b0, last_grant} + grant_off + 1'b1;
    grant_idx = (grant_sum >= NCH_W) ? CHW'(grant_sum - NCH_W) : CHW'(grant_sum);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      timer         <= '0;
      last_grant    <= CHW'(NCH - 1);
      bus.ack       <= '0;
      bus.chan_sel  <= '0;
      bus.eng_start <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.res_chan  <= '0;
      bus.res_se    <= '0;
      bus.res_sez   <= '0;
      bus.res_err   <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      bus.eng_start <= 1'b0;
      bus.ack       <= '0;
      bus.res_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.enable && grant_hit && bus.eng_done) begin
            bus.chan_sel <= grant_idx;
            bus.busy     <= 1'b1;
            state        <= LAUNCH;
          end
        end
        LAUNCH: begin
          bus.eng_start <= 1'b1;
          timer         <= '0;
          state         <= WAIT_LOW;
        end
        WAIT_LOW, WAIT_HIGH: begin
          if ((state == WAIT_LOW) && !bus.eng_done) begin
            state <= WAIT_HIGH;
          end else if ((state == WAIT_HIGH) && bus.eng_done) begin
            bus.res_se    <= bus.eng_se;
            bus.res_sez   <= bus.eng_sez;
            bus.res_err   <= 1'b0;
            bus.res_chan  <= bus.chan_sel;
            bus.res_valid <= 1'b1;
            bus.ack       <= ONE << bus.chan_sel;
            state         <= CAPTURE;
          end else if (timer == TMAX) begin
            // watchdog: total wait across both phases is bounded, timer is shared
            bus.res_se    <= '0;
            bus.res_sez   <= '0;
            bus.res_err   <= 1'b1;
            bus.res_chan  <= bus.chan_sel;
            bus.res_valid <= 1'b1;
            bus.ack       <= ONE << bus.chan_sel;
            state         <= CAPTURE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        CAPTURE: begin
          last_grant <= bus.chan_sel;
          bus.busy   <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fmac_chan_sched.sv
// Directed bench for fmac_chan_sched with a behavioural done-low-for-N-cycles engine.
module tb_fmac_chan_sched;
  logic clk;
  logic reset;

  fmac_chan_sched_if #(.NCH(4), .CHW(2)) bus ();

  fmac_chan_sched #(.NCH(4), .CHW(2), .TIMEOUT(200), .TW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // engine model: done drops the cycle after start and stays low eng_lat cycles
  logic        done_r;
  int          eng_cnt;
  int          eng_lat;
  logic        eng_ignore;
  logic        force_low;
  logic [14:0] se_v, sez_v;

  always @(posedge clk) begin
    if (reset) begin
      done_r  <= 1'b1;
      eng_cnt <= 0;
    end else if (eng_cnt != 0) begin
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 1) done_r <= 1'b1;
    end else if (bus.eng_start && !eng_ignore) begin
      done_r  <= 1'b0;
      eng_cnt <= eng_lat;
    end
  end

  assign bus.eng_done = done_r & ~force_low;
  assign bus.eng_se   = se_v;
  assign bus.eng_sez  = sez_v;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_valid(input int max, output int cyc, output bit ok, output int starts);
    cyc = 0; ok = 1'b0; starts = 0;
    while (!ok && cyc < max) begin
      @(negedge clk);
      cyc++;
      if (bus.eng_start) starts++;
      if (bus.res_valid) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({bus.ack, bus.eng_start, bus.res_valid, bus.res_err, bus.busy, bus.chan_sel, bus.res_chan} !== 13'd0) begin
      errors++;
      $display("FAIL reset_ctrl: got ack=%b start=%b valid=%b err=%b busy=%b sel=%0d rchan=%0d, want all 0",
               bus.ack, bus.eng_start, bus.res_valid, bus.res_err, bus.busy, bus.chan_sel, bus.res_chan);
    end
    checks++;
    if ({bus.res_se, bus.res_sez} !== 30'd0) begin
      errors++; $display("FAIL reset_res: got se=%h sez=%h want 0", bus.res_se, bus.res_sez);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int cyc, starts; bit ok;
    eng_lat = 147; se_v = 15'h1234; sez_v = 15'h0ABC;
    bus.enable = 1'b1; bus.req = 4'b0100;
    @(negedge clk);
    checks++;
    if (bus.chan_sel !== 2'd2 || bus.eng_start !== 1'b0) begin
      errors++; $display("FAIL single_sel_setup: got sel=%0d start=%b want sel=2 start=0", bus.chan_sel, bus.eng_start);
    end
    @(negedge clk);
    checks++;
    if (bus.eng_start !== 1'b1 || bus.chan_sel !== 2'd2) begin
      errors++; $display("FAIL single_start: got start=%b sel=%0d want 1/2", bus.eng_start, bus.chan_sel);
    end
    bus.req = 4'b0000;  // dropped mid-service, must still be acked
    wait_valid(400, cyc, ok, starts);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL single_timeout: no res_valid after %0d cycles", cyc);
    end
    checks++;
    if (cyc != 149 || starts != 0) begin
      errors++; $display("FAIL single_latency: got cyc=%0d extra_starts=%0d want 149/0", cyc, starts);
    end
    checks++;
    if (bus.ack !== 4'b0100 || bus.res_chan !== 2'd2 || bus.res_err !== 1'b0) begin
      errors++; $display("FAIL single_ack: got ack=%b chan=%0d err=%b want 0100/2/0", bus.ack, bus.res_chan, bus.res_err);
    end
    checks++;
    if (bus.res_se !== 15'h1234 || bus.res_sez !== 15'h0ABC) begin
      errors++; $display("FAIL single_data: got se=%h sez=%h want 1234/0abc", bus.res_se, bus.res_sez);
    end
    @(negedge clk);
    checks++;
    if (bus.ack !== 4'b0000 || bus.res_valid !== 1'b0 || bus.res_se !== 15'h1234 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL single_after: got ack=%b valid=%b se=%h busy=%b want 0000/0/1234/0",
                         bus.ack, bus.res_valid, bus.res_se, bus.busy);
    end
  endtask

  task automatic test_done_low();
    int cyc, starts; bit ok; bit seen;
    eng_lat = 1; force_low = 1'b1; bus.req = 4'b0001; seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.eng_start || bus.busy) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL doneLow_hold: got activity=%b want 0", seen);
    end
    force_low = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.chan_sel !== 2'd0 || bus.eng_start !== 1'b0) begin
      errors++; $display("FAIL doneLow_grant: got sel=%0d start=%b want 0/0", bus.chan_sel, bus.eng_start);
    end
    @(negedge clk);
    checks++;
    if (bus.eng_start !== 1'b1) begin
      errors++; $display("FAIL doneLow_start: got start=%b want 1", bus.eng_start);
    end
    wait_valid(20, cyc, ok, starts);
    checks++;
    if (!ok || cyc != 3 || bus.res_chan !== 2'd0 || bus.ack !== 4'b0001) begin
      errors++; $display("FAIL min_latency: got ok=%b cyc=%0d chan=%0d ack=%b want 1/3/0/0001", ok, cyc, bus.res_chan, bus.ack);
    end
    bus.req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [3:0] one;
    logic [3:0] exp_ack;
    int cyc; bit ok; bit stable;
    one = 4'b0001;
    do_reset();
    eng_lat = 1; bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_ack = one << (k % 4);
      cyc = 0; ok = 1'b0; stable = 1'b1;
      while (!ok && cyc < 30) begin
        @(negedge clk);
        cyc++;
        if (bus.busy && bus.chan_sel !== 2'(k % 4)) stable = 1'b0;
        if (bus.res_valid) ok = 1'b1;
      end
      checks++;
      if (!ok || bus.ack !== exp_ack || bus.res_chan !== 2'(k % 4) || !stable) begin
        errors++; $display("FAIL rr_op%0d: got ok=%b ack=%b chan=%0d sel_stable=%b want ack=%b chan=%0d",
                           k, ok, bus.ack, bus.res_chan, stable, exp_ack, k % 4);
      end
      if (k == 4) bus.req = 4'b0000;
      @(negedge clk);
      checks++;
      if (bus.ack !== 4'b0000) begin
        errors++; $display("FAIL rr_pulse%0d: got ack=%b want 0000", k, bus.ack);
      end
    end
  endtask

  task automatic test_timeout();
    int cyc, starts; bit ok;
    eng_ignore = 1'b1; eng_lat = 1; bus.req = 4'b0011;
    @(negedge clk);
    checks++;
    if (bus.chan_sel !== 2'd1) begin
      errors++; $display("FAIL to_grant: got sel=%0d want 1", bus.chan_sel);
    end
    @(negedge clk);
    wait_valid(300, cyc, ok, starts);
    checks++;
    if (!ok || cyc != 200) begin
      errors++; $display("FAIL to_latency: got ok=%b cyc=%0d want 1/200", ok, cyc);
    end
    checks++;
    if (bus.res_err !== 1'b1 || bus.res_se !== 15'd0 || bus.res_sez !== 15'd0 || bus.ack !== 4'b0010 || bus.res_chan !== 2'd1) begin
      errors++; $display("FAIL to_result: got err=%b se=%h sez=%h ack=%b chan=%0d want 1/0/0/0010/1",
                         bus.res_err, bus.res_se, bus.res_sez, bus.ack, bus.res_chan);
    end
    eng_ignore = 1'b0; bus.req = 4'b0001;
    wait_valid(20, cyc, ok, starts);
    checks++;
    if (!ok || bus.res_chan !== 2'd0 || bus.res_err !== 1'b0 || bus.res_se !== 15'h1234) begin
      errors++; $display("FAIL to_next: got ok=%b chan=%0d err=%b se=%h want 1/0/0/1234",
                         ok, bus.res_chan, bus.res_err, bus.res_se);
    end
    bus.req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int cyc, starts; bit ok;
    eng_lat = 147; bus.req = 4'b1000;
    @(negedge clk);
    checks++;
    if (bus.chan_sel !== 2'd3) begin
      errors++; $display("FAIL rmid_grant: got sel=%0d want 3", bus.chan_sel);
    end
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.ack, bus.eng_start, bus.res_valid, bus.res_err, bus.busy, bus.chan_sel, bus.res_chan} !== 13'd0 ||
        {bus.res_se, bus.res_sez} !== 30'd0) begin
      errors++; $display("FAIL rmid_clear: got ack=%b start=%b valid=%b err=%b busy=%b sel=%0d se=%h want all 0",
                         bus.ack, bus.eng_start, bus.res_valid, bus.res_err, bus.busy, bus.chan_sel, bus.res_se);
    end
    reset = 1'b0; bus.req = 4'b1001;
    @(negedge clk);
    checks++;
    if (bus.chan_sel !== 2'd0 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL rmid_regrant: got sel=%0d busy=%b want 0/1", bus.chan_sel, bus.busy);
    end
    wait_valid(400, cyc, ok, starts);
    checks++;
    if (!ok || bus.res_chan !== 2'd0 || bus.ack !== 4'b0001) begin
      errors++; $display("FAIL rmid_done: got ok=%b chan=%0d ack=%b want 1/0/0001", ok, bus.res_chan, bus.ack);
    end
    bus.req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_enable();
    int cyc, starts; bit ok; bit seen;
    eng_lat = 147; bus.enable = 1'b0; bus.req = 4'b0010; seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.eng_start || bus.busy) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL en_hold: got activity=%b want 0", seen);
    end
    bus.enable = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.chan_sel !== 2'd1 || bus.eng_start !== 1'b0) begin
      errors++; $display("FAIL en_grant: got sel=%0d start=%b want 1/0", bus.chan_sel, bus.eng_start);
    end
    @(negedge clk);
    checks++;
    if (bus.eng_start !== 1'b1) begin
      errors++; $display("FAIL en_start: got start=%b want 1", bus.eng_start);
    end
    bus.enable = 1'b0;  // dropped in flight: operation still completes
    wait_valid(400, cyc, ok, starts);
    checks++;
    if (!ok || bus.res_chan !== 2'd1 || bus.res_err !== 1'b0) begin
      errors++; $display("FAIL en_complete: got ok=%b chan=%0d err=%b want 1/1/0", ok, bus.res_chan, bus.res_err);
    end
    seen = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.busy) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL en_nogrant: got busy_seen=%b want 0", seen);
    end
    bus.enable = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1 || bus.chan_sel !== 2'd1) begin
      errors++; $display("FAIL en_rerequest: got busy=%b sel=%0d want 1/1", bus.busy, bus.chan_sel);
    end
    bus.req = 4'b0000;
  endtask

  initial begin
    reset = 1'b1; bus.enable = 1'b0; bus.req = 4'b0000;
    force_low = 1'b0; eng_ignore = 1'b0; eng_lat = 1; se_v = 15'd0; sez_v = 15'd0;
    test_reset();
    test_single();
    test_done_low();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_enable();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
